// File: rtl/prog_loader.sv
// Boot-time program loader: turns a little-endian byte stream (32-bit word
// count header, then instruction words) into sequential instruction-memory
// writes starting at word 0, and keeps the core in reset until a complete,
// valid program has been written.
module prog_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    // Memory depth as a 32-bit value so the header comparison is a plain
    // unsigned 32-bit compare.
    localparam logic [31:0]         DEPTH_W = 32'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    // Byte lane of the next accepted byte, and the three low bytes collected
    // so far. The top byte is never stored: it arrives on in_data in the same
    // cycle the word is consumed.
    logic [1:0]            lane;
    logic [23:0]           asm_lo;
    logic [ADDR_WIDTH:0]   n_words;

    logic                  accept;
    logic                  word_last;
    logic [31:0]           word_full;
    logic [ADDR_WIDTH:0]   wl_inc;
    logic                  hdr_zero;
    logic                  hdr_over;

    // Place a byte into its lane of the partial word; lane 3 is never stored.
    function automatic logic [23:0] insert_byte(
        input logic [23:0] word,
        input logic [1:0]  sel,
        input logic [7:0]  b
    );
        logic [23:0] r;
        r = word;
        case (sel)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r        = word;
        endcase
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: header evaluation, last-word detection, restart.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (word_last) begin
                    if (hdr_zero) begin
                        state_nxt = S_DONE;
                    end else if (hdr_over) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_last && (wl_inc == n_words)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_HDR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the registered state plus the handshake it implies.
    always_comb begin
        in_ready  = (state == S_HDR) || (state == S_DATA);
        accept    = in_ready && in_valid;
        word_last = accept && (lane == 2'd3);
        word_full = {in_data, asm_lo};
        wl_inc    = words_loaded + WL_ONE;
        hdr_zero  = (word_full == 32'd0);
        hdr_over  = (word_full > DEPTH_W);
    end

    // Byte assembly, word count bookkeeping, memory write and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane         <= 2'd0;
            asm_lo       <= 24'd0;
            n_words      <= '0;
            words_loaded <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            core_rst     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            imem_we <= 1'b0;

            if (accept) begin
                asm_lo <= insert_byte(asm_lo, lane, in_data);
                lane   <= lane + 2'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        lane <= 2'd0;
                    end
                end
                S_HDR: begin
                    if (word_last && !hdr_zero && !hdr_over) begin
                        n_words      <= word_full[ADDR_WIDTH:0];
                        words_loaded <= '0;
                    end
                end
                S_DATA: begin
                    if (word_last) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                        imem_wdata   <= word_full;
                        words_loaded <= wl_inc;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        core_rst     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        lane         <= 2'd0;
                    end else begin
                        done     <= 1'b1;
                        core_rst <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (start) begin
                        core_rst     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        lane         <= 2'd0;
                    end else begin
                        error    <= 1'b1;
                        core_rst <= 1'b1;
                    end
                end
                default: begin
                    core_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected memory writes,
// a forked monitor pops and compares them whenever imem_we is seen.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    prog_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          wr_count = 0;
    int          base;
    logic [31:0] prog [0:DEPTH-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] d);
        wr_t e;
        e.addr = idx[AW-1:0];
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Pops one expected write per imem_we cycle; also checks pulse width.
    task automatic run_monitor();
        logic prev_we;
        wr_t  e;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_we) begin
                wr_count++;
                check("we_single_cycle", 32'(prev_we), 32'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write addr=%0h data=%0h", imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(e.addr));
                    check("wr_data", imem_wdata, e.data);
                    check("wl_at_write", 32'(words_loaded), 32'(e.addr) + 32'd1);
                end
            end
            prev_we = imem_we;
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transfers.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL byte_accept got=timeout exp=accept byte=%0h", b);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gapped);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(t[7:0], gapped ? int'($urandom_range(1, 3)) : 0);
            t = t >> 8;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stream(input int n, input bit gapped);
        send_word(32'(n), gapped);
        for (int i = 0; i < n; i++) begin
            push_exp(i, prog[i]);
            send_word(prog[i], gapped);
        end
    endtask

    // Entered at the negedge right after the final accept edge.
    task automatic after_load(input string tag, input int n);
        check({tag, "_done_pre"}, 32'(done), 32'd0);
        check({tag, "_ready_drop"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_core_rst"}, 32'(core_rst), 32'd0);
        check({tag, "_ready_done"}, 32'(in_ready), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'(n));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        fork
            run_monitor();
        join_none
        repeat (3) @(negedge clk);

        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // 1: normal back-to-back load
        prog[0] = 32'h00500093;
        prog[1] = 32'h00A00113;
        base = wr_count;
        pulse_start();
        check("t1_hdr_ready", 32'(in_ready), 32'd1);
        stream(2, 1'b0);
        after_load("t1", 2);
        check("t1_writes", 32'(wr_count - base), 32'd2);

        // 2: same program, gapped stream
        base = wr_count;
        pulse_start();
        stream(2, 1'b1);
        after_load("t2", 2);
        check("t2_writes", 32'(wr_count - base), 32'd2);

        // 3: empty program
        base = wr_count;
        pulse_start();
        stream(0, 1'b0);
        after_load("t3", 0);
        check("t3_writes", 32'(wr_count - base), 32'd0);

        // 4: oversize header (257 words), then recovery with one word
        base = wr_count;
        pulse_start();
        send_word(32'h00000101, 1'b0);
        check("t4_ready_err", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t4_error", 32'(error), 32'd1);
        check("t4_core_rst", 32'(core_rst), 32'd1);
        check("t4_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_error_hold", 32'(error), 32'd1);
        check("t4_ready_hold", 32'(in_ready), 32'd0);
        check("t4_no_writes", 32'(wr_count - base), 32'd0);
        pulse_start();
        check("t4_error_clr", 32'(error), 32'd0);
        check("t4_rst_hold", 32'(core_rst), 32'd1);
        check("t4_ready_again", 32'(in_ready), 32'd1);
        prog[0] = 32'hDEADBEEF;
        stream(1, 1'b0);
        after_load("t4", 1);
        check("t4_error_after", 32'(error), 32'd0);

        // 5: reset after five data bytes, then a full load
        prog[0] = 32'h00500093;
        prog[1] = 32'h00A00113;
        pulse_start();
        send_word(32'd2, 1'b0);
        push_exp(0, prog[0]);
        send_word(prog[0], 1'b0);
        send_byte(prog[1][7:0], 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_ready", 32'(in_ready), 32'd0);
        check("t5_core_rst", 32'(core_rst), 32'd1);
        check("t5_words", 32'(words_loaded), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("t5_idle_ready", 32'(in_ready), 32'd0);
        base = wr_count;
        pulse_start();
        stream(2, 1'b0);
        after_load("t5", 2);
        check("t5_writes", 32'(wr_count - base), 32'd2);

        // 6: start in DONE restarts; start during DATA is ignored
        prog[0] = 32'h11223344;
        prog[1] = 32'hA5A55A5A;
        base = wr_count;
        pulse_start();
        check("t6_core_rst", 32'(core_rst), 32'd1);
        check("t6_done_clr", 32'(done), 32'd0);
        check("t6_words_clr", 32'(words_loaded), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd1);
        send_word(32'd2, 1'b0);
        push_exp(0, prog[0]);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        pulse_start();
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        push_exp(1, prog[1]);
        start = 1'b1;
        send_word(prog[1], 1'b0);
        start = 1'b0;
        after_load("t6", 2);
        check("t6_writes", 32'(wr_count - base), 32'd2);

        // 7: header equal to memory depth fills every word
        for (int i = 0; i < DEPTH; i++) begin
            prog[i] = (32'(i) * 32'h01010101) ^ 32'hA5000000;
        end
        base = wr_count;
        pulse_start();
        stream(DEPTH, 1'b0);
        after_load("t7", DEPTH);
        check("t7_writes", 32'(wr_count - base), 32'(DEPTH));
        check("t7_error", 32'(error), 32'd0);

        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
